// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronisers for both PS/2 lines plus a persistence filter on the clock line.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_fall,
  output logic o_data_sync
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  logic       r_clk_s1;
  logic       r_clk_s2;
  logic       r_dat_s1;
  logic       r_dat_s2;
  logic       r_filt;
  logic [7:0] r_cnt;
  logic       r_fall;
  logic       w_flip;

  // The filtered level flips only after FILTER_LEN consecutive mismatching samples.
  assign w_flip = (r_clk_s2 != r_filt) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_cnt    <= 8'd0;
      r_fall   <= 1'b0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= w_flip && !r_clk_s2;
      if (r_clk_s2 == r_filt || w_flip) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_flip) begin
        r_filt <= r_clk_s2;
      end
    end
  end

  assign o_clk_fall  = r_fall;
  assign o_data_sync = r_dat_s2;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 frame receiver: framing/parity check, timeout abort and E0/F0 prefix folding.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       code_valid,
  output logic       err,
  output logic       busy
);

  localparam int          TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    r_state;
  ps2_state_t    w_state_next;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_tmo;
  logic          r_ext_pend;
  logic          r_rel_pend;
  logic [7:0]    r_code;
  logic          r_extended;
  logic          r_released;
  logic          r_code_valid;
  logic          r_err;

  logic w_fall;
  logic w_data;
  logic w_timeout;
  logic w_stop_evt;
  logic w_frame_ok;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_clk_fall  (w_fall),
    .o_data_sync (w_data)
  );

  // A fall event in the same cycle as an expiring counter takes precedence.
  assign w_timeout  = (r_state != ST_IDLE) && !w_fall && (r_tmo == TMO_LAST);
  assign w_stop_evt = w_fall && (r_state == ST_STOP);
  assign w_frame_ok = w_data && (^{r_shift, r_parity});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_fall && !w_data) w_state_next = ST_DATA;
      ST_DATA:   if (w_fall && r_bitcnt == 3'd7) w_state_next = ST_PARITY;
      ST_PARITY: if (w_fall) w_state_next = ST_STOP;
      ST_STOP:   if (w_fall) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_parity <= 1'b0;
      r_tmo    <= '0;
    end else begin
      if (w_fall || r_state == ST_IDLE) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_fall) begin
        case (r_state)
          ST_IDLE:   r_bitcnt <= 3'd0;
          ST_DATA: begin
            r_shift  <= {w_data, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          ST_PARITY: r_parity <= w_data;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext_pend   <= 1'b0;
      r_rel_pend   <= 1'b0;
      r_code       <= 8'h00;
      r_extended   <= 1'b0;
      r_released   <= 1'b0;
      r_code_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_err        <= 1'b0;
      if (w_stop_evt) begin
        if (!w_frame_ok) begin
          r_err      <= 1'b1;
          r_ext_pend <= 1'b0;
          r_rel_pend <= 1'b0;
        end else if (r_shift == PS2_PFX_EXT) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == PS2_PFX_REL) begin
          r_rel_pend <= 1'b1;
        end else begin
          r_code       <= r_shift;
          r_extended   <= r_ext_pend;
          r_released   <= r_rel_pend;
          r_code_valid <= 1'b1;
          r_ext_pend   <= 1'b0;
          r_rel_pend   <= 1'b0;
        end
      end else if (w_timeout) begin
        r_err      <= 1'b1;
        r_ext_pend <= 1'b0;
        r_rel_pend <= 1'b0;
      end
    end
  end

  assign code       = r_code;
  assign extended   = r_extended;
  assign released   = r_released;
  assign code_valid = r_code_valid;
  assign err        = r_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench: PS/2 frames at 12.5 kHz against a 500 kHz system clock.
`timescale 1ns/1ps
module tb_ps2_rx_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 16384;
  localparam int HALF_BIT_NS    = 40_000;
  localparam int GAP_NS         = 200_000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       extended;
  logic       released;
  logic       code_valid;
  logic       err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  int         n_cv = 0;
  int         n_err = 0;
  int         n_both = 0;
  int         n_wide = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_ext = 1'b0;
  logic       last_rel = 1'b0;
  logic       prev_cv = 1'b0;
  logic       prev_err = 1'b0;

  ps2_rx_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .extended   (extended),
    .released   (released),
    .code_valid (code_valid),
    .err        (err),
    .busy       (busy)
  );

  always #1000 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) begin
      n_cv++;
      last_code = code;
      last_ext  = extended;
      last_rel  = released;
      $display("[TB] event code=%02h ext=%0b rel=%0b", code, extended, released);
    end
    if (err) begin
      n_err++;
      $display("[TB] err strobe");
    end
    if (code_valid && err) n_both++;
    if ((code_valid && prev_cv) || (err && prev_err)) n_wide++;
    prev_cv  = code_valid;
    prev_err = err;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic p, input logic s);
    return {s, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      #(HALF_BIT_NS);
      ps2_clk = 1'b0;
      #(HALF_BIT_NS);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    send_bits(mk_frame(b, p, s), 0, 10);
    ps2_data = 1'b1;
    #(GAP_NS);
  endtask

  task automatic glitch_clk();
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (code !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_code got=%02h exp=00", code); end
    n_tests++; if (extended !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ext got=%b exp=0", extended); end
    n_tests++; if (released !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rel got=%b exp=0", released); end
    n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cv got=%b exp=0", code_valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    $display("[TB] reset checks done");
  endtask

  task automatic test_plain_make();
    int cv0 = n_cv;
    int er0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1);
    n_tests++; if (n_cv - cv0 != 1) begin n_fail++; $display("[TB] FAIL make_count got=%0d exp=1", n_cv - cv0); end
    n_tests++; if (n_err != er0) begin n_fail++; $display("[TB] FAIL make_err got=%0d exp=0", n_err - er0); end
    n_tests++; if ({last_code, last_ext, last_rel} !== {8'h1C, 2'b00}) begin
      n_fail++; $display("[TB] FAIL make_fields got=%02h/%b/%b exp=1C/0/0", last_code, last_ext, last_rel);
    end
    $display("[TB] plain make 1C done");
  endtask

  task automatic test_break();
    int cv0 = n_cv;
    send_frame(8'hF0, 1'b1, 1'b1);
    n_tests++; if (n_cv != cv0) begin n_fail++; $display("[TB] FAIL break_prefix_strobe got=%0d exp=0", n_cv - cv0); end
    send_frame(8'h1C, 1'b0, 1'b1);
    n_tests++; if (n_cv - cv0 != 1) begin n_fail++; $display("[TB] FAIL break_count got=%0d exp=1", n_cv - cv0); end
    n_tests++; if ({last_code, last_ext, last_rel} !== {8'h1C, 2'b01}) begin
      n_fail++; $display("[TB] FAIL break_fields got=%02h/%b/%b exp=1C/0/1", last_code, last_ext, last_rel);
    end
    $display("[TB] break F0 1C done");
  endtask

  task automatic test_ext_break();
    int cv0 = n_cv;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h74, 1'b1, 1'b1);
    n_tests++; if (n_cv - cv0 != 1) begin n_fail++; $display("[TB] FAIL extbrk_count got=%0d exp=1", n_cv - cv0); end
    n_tests++; if ({last_code, last_ext, last_rel} !== {8'h74, 2'b11}) begin
      n_fail++; $display("[TB] FAIL extbrk_fields got=%02h/%b/%b exp=74/1/1", last_code, last_ext, last_rel);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    n_tests++; if ({last_code, last_ext, last_rel} !== {8'h1C, 2'b00}) begin
      n_fail++; $display("[TB] FAIL extbrk_clear got=%02h/%b/%b exp=1C/0/0", last_code, last_ext, last_rel);
    end
    $display("[TB] E0 F0 74 then 1C done");
  endtask

  task automatic test_errors();
    int cv0 = n_cv;
    int er0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1);
    n_tests++; if (n_err - er0 != 1) begin n_fail++; $display("[TB] FAIL parity_err got=%0d exp=1", n_err - er0); end
    send_frame(8'h1C, 1'b0, 1'b0);
    n_tests++; if (n_err - er0 != 2) begin n_fail++; $display("[TB] FAIL stop_err got=%0d exp=2", n_err - er0); end
    n_tests++; if (n_cv != cv0) begin n_fail++; $display("[TB] FAIL err_no_cv got=%0d exp=0", n_cv - cv0); end
    n_tests++; if (code !== 8'h1C) begin n_fail++; $display("[TB] FAIL err_code_hold got=%02h exp=1C", code); end
    $display("[TB] parity and stop errors done");
  endtask

  task automatic test_timeout();
    int er0 = n_err;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 4);
    ps2_data = 1'b1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL tmo_busy_mid got=%b exp=1", busy); end
    repeat (15900) @(negedge clk);
    n_tests++; if (n_err != er0) begin n_fail++; $display("[TB] FAIL tmo_early got=%0d exp=0", n_err - er0); end
    repeat (600) @(negedge clk);
    n_tests++; if (n_err - er0 != 1) begin n_fail++; $display("[TB] FAIL tmo_err got=%0d exp=1", n_err - er0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_busy_after got=%b exp=0", busy); end
    send_frame(8'h1C, 1'b0, 1'b1);
    n_tests++; if ({last_code, last_ext, last_rel} !== {8'h1C, 2'b00} || n_err - er0 != 1) begin
      n_fail++; $display("[TB] FAIL tmo_recover got=%02h/%b/%b errs=%0d exp=1C/0/0 errs=1", last_code, last_ext, last_rel, n_err - er0);
    end
    $display("[TB] timeout done");
  endtask

  task automatic test_glitch_reset();
    int cv0 = n_cv;
    logic [10:0] f = mk_frame(8'h5A, 1'b1, 1'b1);
    ps2_data = 1'b0;
    glitch_clk();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_idle_busy got=%b exp=0", busy); end
    ps2_data = 1'b1;
    send_bits(f, 0, 3);
    glitch_clk();
    glitch_clk();
    send_bits(f, 4, 10);
    ps2_data = 1'b1;
    #(GAP_NS);
    n_tests++; if (n_cv - cv0 != 1 || last_code !== 8'h5A) begin
      n_fail++; $display("[TB] FAIL glitch_frame got=%02h n=%0d exp=5A n=1", last_code, n_cv - cv0);
    end
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 4);
    ps2_data = 1'b1;
    @(negedge clk);
    #200;
    reset_n = 1'b0;
    #300;
    n_tests++; if ({code, extended, released, code_valid, err, busy} !== 13'd0) begin
      n_fail++; $display("[TB] FAIL async_reset got=%02h/%b/%b/%b/%b/%b exp=00/0/0/0/0/0", code, extended, released, code_valid, err, busy);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    cv0 = n_cv;
    send_frame(8'h1C, 1'b0, 1'b1);
    n_tests++; if (n_cv - cv0 != 1 || {last_code, last_ext, last_rel} !== {8'h1C, 2'b00}) begin
      n_fail++; $display("[TB] FAIL post_reset got=%02h/%b/%b n=%0d exp=1C/0/0 n=1", last_code, last_ext, last_rel, n_cv - cv0);
    end
    $display("[TB] glitch and mid-frame reset done");
  endtask

  task automatic test_strobe_rules();
    n_tests++; if (n_both != 0) begin n_fail++; $display("[TB] FAIL strobe_overlap got=%0d exp=0", n_both); end
    n_tests++; if (n_wide != 0) begin n_fail++; $display("[TB] FAIL strobe_width got=%0d exp=0", n_wide); end
    $display("[TB] strobe rules checked");
  endtask

  initial begin
    test_reset();
    test_plain_make();
    test_break();
    test_ext_break();
    test_errors();
    test_timeout();
    test_glitch_reset();
    test_strobe_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
Host-side PS/2 receiver that deserialises frames from a PS/2 clock/data pair into key events for the core. It is the counterpart to the OSD/IO-controller path that emits ps2_clk/ps2_data. It sits between the user-IO PS/2 outputs, or a physical PS/2 port, and the core's keyboard/joystick mapping logic. It synchronises and filters the lines, checks framing and odd parity, folds E0/F0 prefixes into flags, and presents one event per make/break code.

Parameters:
FILTER_LEN, 8, consecutive clk cycles ps2_clk must hold a new level before the filtered clock changes (1..255).
TIMEOUT_CYCLES, 16384, clk cycles without a filtered falling edge mid-frame before the frame is aborted.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
ps2_clk  in  1  PS/2 clock line, asynchronous to clk.
ps2_data  in  1  PS/2 data line, asynchronous to clk.
code  out  8  last scan code received, prefixes stripped; reset 8'h00; held until the next event.
extended  out  1  the event was preceded by E0; reset 0.
released  out  1  the event was preceded by F0 (break); reset 0.
code_valid  out  1  single-cycle strobe marking a new code/extended/released; reset 0.
err  out  1  single-cycle strobe on parity, stop-bit or timeout error; reset 0.
busy  out  1  high while the FSM is not in IDLE; reset 0.

Behaviour:
- Reset is asynchronous on reset_n low. All state clears, FSM goes to IDLE, and the synchroniser and filter flops are set to 1 (bus idle).
- Synchroniser: two flops per line. Filter: a counter reloads whenever the synced ps2_clk equals the filtered level. After FILTER_LEN consecutive mismatching cycles, the filtered level takes the new value. A fall event is a 1->0 change of the filtered level and lasts one cycle. ps2_data is sampled from its synced value in the same cycle as the fall event.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on fall events, except timeout.
  - IDLE: data=0 -> DATA with bitcnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift right with the new bit into bit 7 (LSB first), bitcnt++. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: frame is OK when data=1 and the XOR of the 8 data bits with the parity bit is 1 (odd parity). Either way -> IDLE. If not OK, pulse err.
- Timeout: the counter clears on every fall event and in IDLE. If it reaches TIMEOUT_CYCLES-1 while not in IDLE: FSM -> IDLE, err pulses, pending prefix flags clear. If a fall event and the timeout occur in the same cycle, the fall event wins.
- Prefix handling for a good frame with byte B:
  - B=E0: set ext_pend, no strobe.
  - B=F0: set rel_pend, no strobe.
  - Any other B: code=B, extended=ext_pend, released=rel_pend, code_valid=1; then both pend flags clear.
  - Any err also clears both pend flags.
- Latency: code_valid/err assert in the cycle after the STOP fall event and last exactly one cycle. code_valid and err are never high together.
- busy = (state != IDLE).

Decomposition:
- Package ps2_pkg: FSM state enum; constants PS2_PFX_EXT=8'hE0 and PS2_PFX_REL=8'hF0.
- Sub-module ps2_sync_filter: 2-flop synchronisers plus the glitch filter. Outputs are the filtered clock fall strobe and the synced data.
- The FSM, timeout, prefix logic and output registers stay in ps2_rx_decoder.

Test Plan:
1. Frame 0x1C with parity 0 and stop 1 at a 12.5 kHz bit rate -> exactly one code_valid with code=8'h1C, extended=0, released=0; err stays 0.
2. Frames F0 (p=1) then 1C (p=0) -> no strobe after F0, then one code_valid with code=1C, released=1, extended=0.
3. Frames E0 (p=0), F0 (p=1), 74 (p=1) -> a single code_valid with code=74, extended=1, released=1; the next plain 0x1C reports extended=0, released=0.
4. 0x1C sent with parity bit 1; then a separate frame with stop bit 0 -> one err pulse each, no code_valid, code keeps its previous value.
5. Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES -> err pulses once, busy drops, and a following good 0x1C decodes correctly.
6. Inject ps2_clk glitches of FILTER_LEN-1 cycles, and assert reset_n low mid-frame -> glitches produce no bit shifts; the reset returns all outputs to reset values immediately, and the next frame decodes correctly.
